ps2_transmitter: RTL and testbench
==================================

Name: ps2_transmitter

Overview:
Host-to-device PS/2 transmitter. It sends one command byte to the mouse or keyboard, for example 0xFF reset or 0xF4 enable data reporting during archery-controller bring-up. It runs the full host request-to-send sequence over open-drain clock and data lines and checks the device acknowledge. It sits beside the PS/2 receiver; while tx_busy is high the receiver must ignore line activity.

Parameters:
INHIBIT_CYCLES, 12000, system clocks the host holds PS/2 clock low (120 us at 100 MHz).
SETUP_CYCLES, 200, system clocks data is held low before clock is released (2 us).
TIMEOUT_CYCLES, 2000000, maximum system clocks from clock release to end of frame (20 ms).

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  asynchronous, active-high reset
tx_data  in  8  command byte; sampled on an accepted tx_start
tx_start  in  1  one-cycle request; accepted only when tx_busy=0
ps2_clk_in  in  1  raw PS/2 clock line level (asynchronous)
ps2_data_in  in  1  raw PS/2 data line level (asynchronous)
ps2_clk_oe  out  1  1 = drive PS/2 clock low; 0 = release (pulled high)
ps2_data_oe  out  1  1 = drive PS/2 data low; 0 = release
tx_busy  out  1  high from the cycle after an accepted start until the done/error pulse
tx_done  out  1  one-cycle pulse: frame sent and ACK=0 received
tx_ack_err  out  1  one-cycle pulse: frame sent but ACK read 1
tx_timeout  out  1  one-cycle pulse: device did not finish within TIMEOUT_CYCLES

Behaviour:
- Reset values: all outputs 0, lines released, state IDLE, counters 0. Reset asserted mid-frame releases both lines immediately, without waiting for a clock edge.
- Inputs pass through a 2-flop synchronizer. ps2_clk_in additionally feeds a last-value register. A falling edge (fall) is prev=1, cur=0 on the synchronized signal. Response latency to a line edge is therefore 3 clk cycles.
- On tx_start accept: latch shift register {parity, tx_data}. Parity = ~^tx_data (odd parity). tx_start while busy is ignored, with no queueing.
- IDLE: lines released. An accepted tx_start moves to INHIBIT.
- INHIBIT: clk_oe=1, data_oe=0 for INHIBIT_CYCLES, then go to START.
- START: clk_oe=1, data_oe=1 (start bit 0) for SETUP_CYCLES, then clk_oe=0, bit_cnt=0, timeout counter cleared, go to SEND.
- SEND: data_oe stays at its current value until the next fall.
  - On each fall with bit_cnt 0..8: data_oe = ~shift[0], shift right, bit_cnt++. This drives d0..d7, then parity.
  - On the fall with bit_cnt 9: data_oe=0 (stop bit = released line), bit_cnt=10, go to ACK.
- ACK: on the next fall, sample synchronized data. 0 → WAIT_IDLE with ack_ok=1; 1 → WAIT_IDLE with ack_ok=0.
- WAIT_IDLE: wait until synchronized clk=1 and data=1. Then pulse tx_done (ack_ok=1) or tx_ack_err (ack_ok=0), and go to IDLE with tx_busy=0 in the same cycle as the pulse.
- Timeout: the counter runs in SEND, ACK and WAIT_IDLE. When it reaches TIMEOUT_CYCLES: release both lines, pulse tx_timeout, go to IDLE. Exactly one of done, ack_err or timeout pulses per accepted start.
- Counter widths come from $clog2 of each parameter. bit_cnt is 4 bits.
- Clock-line edges seen in IDLE, INHIBIT or START are ignored.

Test Plan:
- Bench parameters: INHIBIT_CYCLES=20, SETUP_CYCLES=5, TIMEOUT_CYCLES=5000. The device model clocks at a 40-cycle half-period, samples data on the rising edge, and drives ACK low on the 11th falling edge.
- Send 0xF4: clk_oe high 20 cycles, data_oe high throughout START. data_oe after falls 1..10 = 1,1,0,1,0,0,0,0 (d0..d7), 1 (parity 0), 0 (stop). Device decodes 0xF4; tx_done pulses once; tx_busy drops.
- Send 0x00: the parity bit sampled by the device = 1 (data_oe=0 after fall 9); tx_done pulses.
- Device answers ACK=1: tx_ack_err pulses once, tx_done stays 0, and both oe outputs are 0 afterwards.
- Device never clocks after release: tx_timeout pulses exactly 5000 cycles after START ends; lines are released; a new tx_start 0xFF is then accepted and completes.
- Reset asserted during the 5th data bit: ps2_clk_oe and ps2_data_oe are 0 combinationally, and no pulse is emitted. tx_start asserted again while tx_busy=1 is ignored: only one frame goes out.

Source files
------------

// File: rtl/ps2_transmitter.sv
// ps2_transmitter: host-to-device PS/2 command sender.
// It runs the request-to-send sequence: inhibit clock, start bit, release clock.
// It then shifts out 8 data bits, odd parity and stop on device clock falls.
// It finishes by sampling the device ACK and waiting for both lines to idle.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | lines released, waiting for tx_start
// INHIBIT   | host holds clock low to abort any device transfer
// START     | clock still low, data pulled low (start bit) for setup time
// SEND      | clock released; each device fall shifts out d0..d7, parity, stop
// ACK       | next fall samples device acknowledge on data
// WAIT_IDLE | wait for clock and data both high, then report result
module ps2_transmitter #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int SETUP_CYCLES   = 200,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_ack_err,
  output logic       tx_timeout
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int SET_W = $clog2(SETUP_CYCLES + 1);
  localparam int PH_W  = (INH_W > SET_W) ? INH_W : SET_W;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  // Down-counters load N-1 and terminate at zero, giving exactly N cycles.
  localparam logic [PH_W-1:0]  INH_LOAD = PH_W'(INHIBIT_CYCLES - 1);
  localparam logic [PH_W-1:0]  SET_LOAD = PH_W'(SETUP_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t            state_q;
  logic              clk_s1_q, clk_s2_q, clk_prev_q;
  logic              data_s1_q, data_s2_q;
  logic              clk_oe_q, data_oe_q;
  logic              busy_q, done_q, err_q, tmo_q;
  logic              ack_ok_q;
  logic [8:0]        shift_q;
  logic [3:0]        bit_cnt_q;
  logic [PH_W-1:0]   phase_cnt_q;
  logic [TMO_W-1:0]  tmo_cnt_q;
  logic              parity_d;
  logic              fall;

  assign parity_d = ~^tx_data;
  assign fall     = clk_prev_q & ~clk_s2_q;

  // Two-flop synchronizers on both lines plus a history flop for clock edges.
  // Idle level is high, so reset to 1 to avoid a false fall after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      data_s1_q  <= ps2_data_in;
      data_s2_q  <= data_s1_q;
    end
  end

  // Transmit sequencer with registered line enables and status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      tmo_q       <= 1'b0;
      ack_ok_q    <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      phase_cnt_q <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      tmo_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          if (tx_start) begin
            shift_q     <= {parity_d, tx_data};
            busy_q      <= 1'b1;
            clk_oe_q    <= 1'b1;
            phase_cnt_q <= INH_LOAD;
            state_q     <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          if (phase_cnt_q == '0) begin
            data_oe_q   <= 1'b1;
            phase_cnt_q <= SET_LOAD;
            state_q     <= S_START;
          end else begin
            phase_cnt_q <= phase_cnt_q - 1'b1;
          end
        end

        S_START: begin
          if (phase_cnt_q == '0) begin
            clk_oe_q  <= 1'b0;
            bit_cnt_q <= '0;
            tmo_cnt_q <= TMO_LOAD;
            state_q   <= S_SEND;
          end else begin
            phase_cnt_q <= phase_cnt_q - 1'b1;
          end
        end

        S_SEND, S_ACK, S_WAIT_IDLE: begin
          if (tmo_cnt_q == '0) begin
            // Device stalled: give the lines back and report.
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            tmo_q     <= 1'b1;
            bit_cnt_q <= '0;
            state_q   <= S_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q - 1'b1;
            case (state_q)
              S_SEND: begin
                if (fall) begin
                  if (bit_cnt_q == 4'd9) begin
                    data_oe_q <= 1'b0;
                    bit_cnt_q <= 4'd10;
                    state_q   <= S_ACK;
                  end else begin
                    data_oe_q <= ~shift_q[0];
                    shift_q   <= {1'b0, shift_q[8:1]};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                  end
                end
              end
              S_ACK: begin
                if (fall) begin
                  ack_ok_q <= ~data_s2_q;
                  state_q  <= S_WAIT_IDLE;
                end
              end
              S_WAIT_IDLE: begin
                if (clk_s2_q && data_s2_q) begin
                  done_q    <= ack_ok_q;
                  err_q     <= ~ack_ok_q;
                  busy_q    <= 1'b0;
                  bit_cnt_q <= '0;
                  state_q   <= S_IDLE;
                end
              end
              default: ;
            endcase
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Gating with reset releases the bus at once, not at the next flop update.
  assign ps2_clk_oe  = clk_oe_q & ~reset;
  assign ps2_data_oe = data_oe_q & ~reset;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign tx_ack_err  = err_q;
  assign tx_timeout  = tmo_q;

endmodule

// File: tb/tb_ps2_transmitter.sv
// Bench for ps2_transmitter: open-drain line model plus a behavioural PS/2 device.
module tb_ps2_transmitter;
  localparam int INH  = 20;
  localparam int SET  = 5;
  localparam int TMO  = 5000;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       tx_busy, tx_done, tx_ack_err, tx_timeout;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_err    = 0;
  int n_tmo    = 0;
  logic pulse_busy = 1'b0;

  // Wired-AND bus: a line is low whenever either side pulls it.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_transmitter #(
    .INHIBIT_CYCLES(INH),
    .SETUP_CYCLES  (SET),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_ack_err (tx_ack_err),
    .tx_timeout (tx_timeout)
  );

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (tx_done)    n_done++;
    if (tx_ack_err) n_err++;
    if (tx_timeout) n_tmo++;
    if (tx_done || tx_ack_err || tx_timeout) pulse_busy = tx_busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Frame bits in wire order: d0..d7, odd parity, stop.
  function automatic logic [9:0] frame_bits(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

  task automatic start_tx(input string tag, input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
    check({tag, "_busy_on_start"}, 32'(tx_busy), 32'd1);
  endtask

  // Measures the inhibit and start-bit phases until the host releases clock.
  task automatic host_request(input string tag);
    int inh = 0;
    int st  = 0;
    int n   = 0;
    while (ps2_clk_oe && n < 200) begin
      if (ps2_data_oe) st++;
      else inh++;
      n++;
      tick(1);
    end
    check({tag, "_inhibit_cycles"}, inh, INH);
    check({tag, "_setup_cycles"}, st, SET);
    check({tag, "_clk_released"}, 32'(ps2_clk_oe), 32'd0);
    check({tag, "_start_bit_held"}, 32'(ps2_data_oe), 32'd1);
  endtask

  // Device clocks 11 pulses, samples on rises, drives ACK on the 11th fall.
  task automatic device_frame(input string tag, input logic [7:0] d, input logic ack_val,
                              input bit poke, output logic [9:0] got);
    logic [9:0] bits;
    logic       e;
    bits = frame_bits(d);
    got  = '0;
    tick(10);
    for (int i = 1; i <= 11; i++) begin
      dev_clk_low = 1'b1;
      if (i == 11 && !ack_val) dev_data_low = 1'b1;
      if (poke && i == 3) begin
        tx_data  = 8'hAB;
        tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0;
        tick(HALF - 1);
      end else begin
        tick(HALF);
      end
      if (i <= 10) begin
        e = ~bits[i-1];
        check($sformatf("%s_data_oe_fall%0d", tag, i), 32'(ps2_data_oe), 32'(e));
      end
      dev_clk_low = 1'b0;
      if (i <= 10) got[i-1] = ps2_data_in;
      tick(HALF);
    end
    dev_data_low = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input logic ack_val, input bit poke);
    int d0, e0, t0;
    logic [9:0] got;
    logic       par;
    d0 = n_done;
    e0 = n_err;
    t0 = n_tmo;
    start_tx(tag, d);
    host_request(tag);
    device_frame(tag, d, ack_val, poke, got);
    tick(20);
    par = ~^d;
    check({tag, "_decoded"}, 32'(got[7:0]), 32'(d));
    check({tag, "_parity"}, 32'(got[8]), 32'(par));
    check({tag, "_stop"}, 32'(got[9]), 32'd1);
    check({tag, "_done_pulses"}, n_done - d0, ack_val ? 0 : 1);
    check({tag, "_ackerr_pulses"}, n_err - e0, ack_val ? 1 : 0);
    check({tag, "_timeout_pulses"}, n_tmo - t0, 0);
    check({tag, "_busy_at_pulse"}, 32'(pulse_busy), 32'd0);
    check({tag, "_busy_after"}, 32'(tx_busy), 32'd0);
    check({tag, "_oe_after"}, {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    if (poke) begin
      tick(300);
      check({tag, "_no_second_frame"}, 32'(ps2_clk_oe), 32'd0);
      check({tag, "_still_idle"}, 32'(tx_busy), 32'd0);
      check({tag, "_single_done"}, n_done - d0, 1);
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       a;
    int         n, d0, e0, t0;

    reset = 1'b1;
    tick(3);
    check("reset_outputs",
          {26'd0, ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_ack_err, tx_timeout}, 32'd0);
    reset = 1'b0;
    tick(2);

    run_frame("f4", 8'hF4, 1'b0, 1'b0);
    run_frame("zero", 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      d = 8'($urandom_range(0, 255));
      a = 1'($urandom_range(0, 1));
      run_frame($sformatf("rand%0d", k), d, a, 1'b0);
    end
    run_frame("ackerr", 8'h3C, 1'b1, 1'b0);

    // Device never clocks after the host releases the clock line.
    d0 = n_done;
    e0 = n_err;
    t0 = n_tmo;
    start_tx("tmo", 8'h96);
    host_request("tmo");
    n = 0;
    while (!tx_timeout && n < TMO + 1000) begin
      tick(1);
      n++;
    end
    check("tmo_latency", n, TMO);
    check("tmo_pulse", 32'(tx_timeout), 32'd1);
    check("tmo_lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("tmo_busy_low", 32'(tx_busy), 32'd0);
    tick(1);
    check("tmo_count", n_tmo - t0, 1);
    check("tmo_no_done", (n_done - d0) + (n_err - e0), 0);
    run_frame("ff_after_tmo", 8'hFF, 1'b0, 1'b0);

    run_frame("busy_ignore", 8'h5A, 1'b0, 1'b1);

    // Reset while the fifth data bit (d4 of 0xA5 = 0, so data pulled low) is on the line.
    d0 = n_done;
    e0 = n_err;
    t0 = n_tmo;
    start_tx("rst", 8'hA5);
    host_request("rst");
    tick(10);
    for (int i = 1; i <= 5; i++) begin
      dev_clk_low = 1'b1;
      tick(HALF);
      if (i < 5) begin
        dev_clk_low = 1'b0;
        tick(HALF);
      end
    end
    check("rst_d4_driven", 32'(ps2_data_oe), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_oe_immediate", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("rst_busy_cleared", 32'(tx_busy), 32'd0);
    dev_clk_low = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(100);
    check("rst_no_pulse", (n_done - d0) + (n_err - e0) + (n_tmo - t0), 0);
    check("rst_lines_idle", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    run_frame("after_rst", 8'hF4, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
